// File: rtl/axi_dma_pkg.sv
// Shared definitions for the AXI DMA packet gate.
// Holds the gate FSM encoding and the AXIS beat width helper.
package axi_dma_pkg;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        DRAIN     = 2'd1,
        WAIT_INTR = 2'd2
    } gate_state_t;

    // Beat is {tlast, tkeep, tdata}
    function automatic int beat_width(input int tdata_width);
        return tdata_width + tdata_width / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous beat FIFO with registered storage.
// Writes become visible at the output one cycle after they land.
module axis_sync_fifo #(
    parameter int               DEPTH      = 4,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             last_entry
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      wr_vis;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;

    assign used       = wr_ptr - rd_ptr;
    assign full       = (used == (AW + 1)'(DEPTH));
    assign last_entry = (used == (AW + 1)'(1));
    // Empty is judged against the delayed write pointer for the extra stage
    assign empty      = (rd_ptr == wr_vis);
    assign dout       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            wr_vis <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_WORD;
            end
        end else begin
            wr_vis <= wr_ptr;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_dma_pkt_gate.sv
// AXIS gate feeding DMA S2MM: passes a fixed packet count per transfer,
// then stays closed until the DMA interrupt edge re-arms it.
module axi_dma_pkt_gate
    import axi_dma_pkg::*;
#(
    parameter int TDATA_WIDTH   = 128,
    parameter int FIFO_DEPTH    = 4,
    parameter int PKTS_PER_XFER = 1,
    parameter int INTR_NEGEDGE  = 1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                     S_AXIS_TLAST,
    input  logic                     S_AXIS_TVALID,
    output logic                     S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                     M_AXIS_TLAST,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY,
    input  logic                     AXIDMA_S2MM_INTR_IN,
    output logic [1:0]               GATE_STATE,
    output logic [15:0]              XFER_COUNT
);
    localparam int BW = beat_width(TDATA_WIDTH);
    localparam logic [15:0] LAST_PKT = 16'(PKTS_PER_XFER - 1);

    gate_state_t    state;
    gate_state_t    state_nx;
    logic [15:0]    pkt_cnt;
    logic [15:0]    pkt_cnt_nx;
    logic [15:0]    xfer_nx;
    logic           rearm_pend;
    logic           rearm_nx;
    logic           intr_d;
    logic           rearm_edge;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_last;
    logic           s_hs;
    logic           m_hs;
    logic [BW-1:0]  fifo_dout;

    assign rearm_edge = (INTR_NEGEDGE != 0) ? (intr_d & ~AXIDMA_S2MM_INTR_IN)
                                            : (~intr_d & AXIDMA_S2MM_INTR_IN);

    assign S_AXIS_TREADY = ~ARESET & (state == ARMED) & ~fifo_full;
    assign M_AXIS_TVALID = ~fifo_empty & (state != WAIT_INTR);
    assign s_hs          = S_AXIS_TVALID & S_AXIS_TREADY;
    assign m_hs          = M_AXIS_TVALID & M_AXIS_TREADY;
    assign {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} = fifo_dout;
    assign GATE_STATE    = state;

    axis_sync_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .WIDTH      (BW),
        .RESET_WORD (BW'({TDATA_WIDTH{1'b1}}))
    ) u_fifo (
        .clk        (ACLK),
        .rst        (ARESET),
        .push       (s_hs),
        .din        ({S_AXIS_TLAST, S_AXIS_TKEEP, S_AXIS_TDATA}),
        .pop        (m_hs),
        .dout       (fifo_dout),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .last_entry (fifo_last)
    );

    always_comb begin
        state_nx   = state;
        pkt_cnt_nx = pkt_cnt;
        rearm_nx   = rearm_pend;
        xfer_nx    = XFER_COUNT;
        case (state)
            ARMED: begin
                if (s_hs && S_AXIS_TLAST) begin
                    if (pkt_cnt == LAST_PKT) begin
                        pkt_cnt_nx = '0;
                        state_nx   = DRAIN;
                    end else begin
                        pkt_cnt_nx = pkt_cnt + 16'd1;
                    end
                end
            end
            DRAIN: begin
                if (rearm_edge) begin
                    rearm_nx = 1'b1;
                end
                // The closing TLAST is always the last buffered beat
                if (m_hs && M_AXIS_TLAST && fifo_last) begin
                    xfer_nx = XFER_COUNT + 16'd1;
                    if (rearm_pend || rearm_edge) begin
                        state_nx = ARMED;
                        rearm_nx = 1'b0;
                    end else begin
                        state_nx = WAIT_INTR;
                    end
                end
            end
            WAIT_INTR: begin
                if (rearm_edge) begin
                    state_nx = ARMED;
                end
            end
            default: state_nx = ARMED;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= ARMED;
            pkt_cnt    <= '0;
            rearm_pend <= 1'b0;
            XFER_COUNT <= '0;
            intr_d     <= 1'b0;
        end else begin
            state      <= state_nx;
            pkt_cnt    <= pkt_cnt_nx;
            rearm_pend <= rearm_nx;
            XFER_COUNT <= xfer_nx;
            intr_d     <= AXIDMA_S2MM_INTR_IN;
        end
    end

endmodule
